// File: rtl/du_pkg.sv
// Shared opcode constants and decoded-slot types for the N-way decode stage.
package du_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;

  localparam int INST_W  = 32;
  localparam int SHAMT_W = 6;

  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [4:0]         rd_addr;
    logic               rd_wen;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [SHAMT_W-1:0] shamt;
  } du_ctrl_t;

  localparam int CTRL_W = $bits(du_ctrl_t);

endpackage

// File: rtl/du_decode_slot.sv
// Single-way combinational RV decoder. Optional illegal-instruction
// detection is enabled by defining DU_ILLEGAL_CHECK_EN.
module du_decode_slot
  import du_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              vld_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic              rs1_ren_o,
  output logic              rs2_ren_o,
  output du_ctrl_t          ctrl_o,
  output logic [XLEN-1:0]   imm_o
`ifdef DU_ILLEGAL_CHECK_EN
  ,output logic             illegal_o
`endif
);

`ifdef DU_ILLEGAL_CHECK_EN
  localparam bit ILL_CHK = 1'b1;
`else
  localparam bit ILL_CHK = 1'b0;
`endif

  function automatic logic signed [31:0] imm32(input imm_sel_e sel, input logic [31:0] in);
    case (sel)
      IMM_I:   return {{20{in[31]}}, in[31:20]};
      IMM_S:   return {{20{in[31]}}, in[31:25], in[11:7]};
      IMM_B:   return {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      IMM_U:   return {in[31:12], 12'b0};
      IMM_J:   return {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  function automatic logic [SHAMT_W-1:0] shamt_of(input logic [31:0] in);
    return (XLEN == 64) ? in[25:20] : {1'b0, in[24:20]};
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       r1, r2, we, unk, sh_en, sys_rw, ill, keep;
  imm_sel_e   sel;
  logic signed [31:0] imm_s;

  assign opc    = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign sys_rw = (f3 != 3'b000) && (f3 != 3'b100);

  always_comb begin
    r1    = 1'b0;
    r2    = 1'b0;
    we    = 1'b0;
    unk   = 1'b0;
    sh_en = 1'b0;
    sel   = IMM_R;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin we = 1'b1; sel = IMM_U; end
      OPC_JAL:            begin we = 1'b1; sel = IMM_J; end
      OPC_JALR:           begin r1 = 1'b1; we = 1'b1; sel = IMM_I; end
      OPC_BRANCH:         begin r1 = 1'b1; r2 = 1'b1; sel = IMM_B; end
      OPC_LOAD:           begin r1 = 1'b1; sel = IMM_I; end
      OPC_STORE:          begin r1 = 1'b1; r2 = 1'b1; sel = IMM_S; end
      OPC_OP_IMM: begin
        r1    = 1'b1;
        we    = 1'b1;
        sel   = IMM_I;
        sh_en = (f3 == 3'b001) || (f3 == 3'b101);
      end
      OPC_OP:             begin r1 = 1'b1; r2 = 1'b1; we = (f7 != 7'b0000001); end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin r1 = 1'b1; we = 1'b1; sel = IMM_I; end
        else unk = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin r1 = 1'b1; r2 = 1'b1; we = (f7 != 7'b0000001); end
        else unk = 1'b1;
      end
      OPC_AMO, OPC_OP_FP: begin r1 = 1'b1; r2 = 1'b1; we = 1'b1; end
      OPC_SYSTEM:         begin r1 = sys_rw; we = sys_rw; sel = IMM_I; end
      default:            unk = 1'b1;
    endcase
  end

  // Illegal ways lose all register-file side effects.
  assign ill  = ILL_CHK && vld_i &&
                (unk || ((opc == OPC_SYSTEM) && (f3 == 3'b100)) ||
                 ((XLEN == 32) && sh_en && inst_i[25]));
  assign keep = vld_i && !ill;

  assign rs1_ren_o  = keep && r1;
  assign rs2_ren_o  = keep && r2;
  assign rs1_addr_o = rs1_ren_o ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = rs2_ren_o ? inst_i[24:20] : 5'd0;

  assign imm_s = imm32(sel, inst_i);
  assign imm_o = vld_i ? XLEN'(imm_s) : '0;

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.rd_wen  = keep && we;
    ctrl_o.rd_addr = ctrl_o.rd_wen ? inst_i[11:7] : 5'd0;
    if (vld_i) begin
      ctrl_o.opcode = opc;
      ctrl_o.funct3 = f3;
      ctrl_o.funct7 = f7;
      ctrl_o.shamt  = sh_en ? shamt_of(inst_i) : '0;
    end
  end

`ifdef DU_ILLEGAL_CHECK_EN
  assign illegal_o = ill;
`endif

endmodule

// File: rtl/decoder_stage_nway.sv
// N-way decode stage with DEPTH-entry bundle FIFO, valid/ready both sides and flush.
// Optional per-way illegal_o output when DU_ILLEGAL_CHECK_EN is defined.
module decoder_stage_nway
  import du_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int WAYS  = 2,
  parameter int DEPTH = 2,
  parameter int PID_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WAYS-1:0]         slot_vld_i,
  input  logic [WAYS*32-1:0]      inst_i,
  input  logic [WAYS*PID_W-1:0]   pid_i,
  output logic [WAYS*5-1:0]       rs1_addr_o,
  output logic [WAYS*5-1:0]       rs2_addr_o,
  output logic [WAYS-1:0]         rs1_ren_o,
  output logic [WAYS-1:0]         rs2_ren_o,
  input  logic [WAYS*XLEN-1:0]    rs1_data_i,
  input  logic [WAYS*XLEN-1:0]    rs2_data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WAYS-1:0]         slot_vld_o,
  output logic [WAYS*PID_W-1:0]   pid_o,
  output logic [WAYS*5-1:0]       rd_addr_o,
  output logic [WAYS-1:0]         rd_wen_o,
  output logic [WAYS*7-1:0]       opcode_o,
  output logic [WAYS*3-1:0]       funct3_o,
  output logic [WAYS*7-1:0]       funct7_o,
  output logic [WAYS*6-1:0]       shamt_o,
  output logic [WAYS*XLEN-1:0]    imm_o,
  output logic [WAYS*XLEN-1:0]    rs1_data_o,
  output logic [WAYS*XLEN-1:0]    rs2_data_o
`ifdef DU_ILLEGAL_CHECK_EN
  ,output logic [WAYS-1:0]        illegal_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  du_ctrl_t        dec_ctrl [WAYS];
  logic [XLEN-1:0] dec_imm  [WAYS];
  logic [XLEN-1:0] wr_rs1   [WAYS];
  logic [XLEN-1:0] wr_rs2   [WAYS];
`ifdef DU_ILLEGAL_CHECK_EN
  logic [WAYS-1:0] dec_ill;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    du_decode_slot #(.XLEN(XLEN)) u_dec (
      .vld_i      (slot_vld_i[w]),
      .inst_i     (inst_i[w*32 +: 32]),
      .rs1_addr_o (rs1_addr_o[w*5 +: 5]),
      .rs2_addr_o (rs2_addr_o[w*5 +: 5]),
      .rs1_ren_o  (rs1_ren_o[w]),
      .rs2_ren_o  (rs2_ren_o[w]),
      .ctrl_o     (dec_ctrl[w]),
      .imm_o      (dec_imm[w])
`ifdef DU_ILLEGAL_CHECK_EN
      ,.illegal_o (dec_ill[w])
`endif
    );
    assign wr_rs1[w] = slot_vld_i[w] ? rs1_data_i[w*XLEN +: XLEN] : '0;
    assign wr_rs2[w] = slot_vld_i[w] ? rs2_data_i[w*XLEN +: XLEN] : '0;
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             push, pop;

  assign ready_o = (count_q != CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Bundle storage: datapath only, validity is carried by count/pointers.
  du_ctrl_t             ctrl_mem_q [DEPTH][WAYS];
  logic [XLEN-1:0]      imm_mem_q  [DEPTH][WAYS];
  logic [XLEN-1:0]      rs1_mem_q  [DEPTH][WAYS];
  logic [XLEN-1:0]      rs2_mem_q  [DEPTH][WAYS];
  logic [WAYS-1:0]      svld_mem_q [DEPTH];
  logic [WAYS*PID_W-1:0] pid_mem_q [DEPTH];
`ifdef DU_ILLEGAL_CHECK_EN
  logic [WAYS-1:0]      ill_mem_q  [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      svld_mem_q[wr_ptr_q] <= slot_vld_i;
      pid_mem_q[wr_ptr_q]  <= pid_i;
`ifdef DU_ILLEGAL_CHECK_EN
      ill_mem_q[wr_ptr_q]  <= dec_ill;
`endif
      for (int w = 0; w < WAYS; w++) begin
        ctrl_mem_q[wr_ptr_q][w] <= dec_ctrl[w];
        imm_mem_q[wr_ptr_q][w]  <= dec_imm[w];
        rs1_mem_q[wr_ptr_q][w]  <= wr_rs1[w];
        rs2_mem_q[wr_ptr_q][w]  <= wr_rs2[w];
      end
    end
  end

  always_comb begin
    slot_vld_o = '0;
    pid_o      = '0;
    rd_addr_o  = '0;
    rd_wen_o   = '0;
    opcode_o   = '0;
    funct3_o   = '0;
    funct7_o   = '0;
    shamt_o    = '0;
    imm_o      = '0;
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (valid_o) begin
      slot_vld_o = svld_mem_q[rd_ptr_q];
      pid_o      = pid_mem_q[rd_ptr_q];
      for (int w = 0; w < WAYS; w++) begin
        rd_addr_o[w*5 +: 5]        = ctrl_mem_q[rd_ptr_q][w].rd_addr;
        rd_wen_o[w]                = ctrl_mem_q[rd_ptr_q][w].rd_wen;
        opcode_o[w*7 +: 7]         = ctrl_mem_q[rd_ptr_q][w].opcode;
        funct3_o[w*3 +: 3]         = ctrl_mem_q[rd_ptr_q][w].funct3;
        funct7_o[w*7 +: 7]         = ctrl_mem_q[rd_ptr_q][w].funct7;
        shamt_o[w*6 +: 6]          = ctrl_mem_q[rd_ptr_q][w].shamt;
        imm_o[w*XLEN +: XLEN]      = imm_mem_q[rd_ptr_q][w];
        rs1_data_o[w*XLEN +: XLEN] = rs1_mem_q[rd_ptr_q][w];
        rs2_data_o[w*XLEN +: XLEN] = rs2_mem_q[rd_ptr_q][w];
      end
    end
  end

`ifdef DU_ILLEGAL_CHECK_EN
  assign illegal_o = valid_o ? ill_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_decoder_stage_nway.sv
// Scoreboard bench for decoder_stage_nway (XLEN=64, WAYS=2, DEPTH=2, PID_W=2).
module tb_decoder_stage_nway;
  localparam int XLEN = 64, WAYS = 2, DEPTH = 2, PID_W = 2;

  logic clk, rst, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [WAYS-1:0]       slot_vld_i, rs1_ren_o, rs2_ren_o, slot_vld_o, rd_wen_o;
  logic [WAYS*32-1:0]    inst_i;
  logic [WAYS*PID_W-1:0] pid_i, pid_o;
  logic [WAYS*5-1:0]     rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [WAYS*XLEN-1:0]  rs1_data_i, rs2_data_i, imm_o, rs1_data_o, rs2_data_o;
  logic [WAYS*7-1:0]     opcode_o, funct7_o;
  logic [WAYS*3-1:0]     funct3_o;
  logic [WAYS*6-1:0]     shamt_o;
`ifdef DU_ILLEGAL_CHECK_EN
  logic [WAYS-1:0]       illegal_o;
`endif

  decoder_stage_nway #(.XLEN(XLEN), .WAYS(WAYS), .DEPTH(DEPTH), .PID_W(PID_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .slot_vld_i(slot_vld_i), .inst_i(inst_i), .pid_i(pid_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs1_ren_o(rs1_ren_o), .rs2_ren_o(rs2_ren_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .valid_o(valid_o), .ready_i(ready_i),
    .slot_vld_o(slot_vld_o), .pid_o(pid_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .imm_o(imm_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o)
`ifdef DU_ILLEGAL_CHECK_EN
    ,.illegal_o(illegal_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r1a, r2a;
    logic        r1e, r2e;
    logic [4:0]  rd;
    logic        we;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  sh;
    logic [63:0] imm, d1, d2;
  } exp_way_t;

  typedef struct packed {
    logic [1:0]         sv;
    logic [3:0]         pid;
    exp_way_t [1:0]     w;
  } exp_bnd_t;

  exp_bnd_t sb_q[$];
  exp_bnd_t cur, mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_way_t model_way(input logic [31:0] in, input logic v,
                                         input logic [63:0] d1, input logic [63:0] d2);
    exp_way_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic sysrw;
    e = '0;
    if (!v) return e;
    op    = in[6:0];
    f3    = in[14:12];
    sysrw = (op == 7'h73) && (f3 != 3'd0) && (f3 != 3'd4);
    e.opc = op; e.f3 = f3; e.f7 = in[31:25]; e.d1 = d1; e.d2 = d2;
    e.r1e = (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h2F, 7'h53}) || sysrw;
    e.r2e = op inside {7'h63, 7'h23, 7'h33, 7'h3B, 7'h2F, 7'h53};
    e.we  = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h1B, 7'h2F, 7'h53}) ||
            ((op inside {7'h33, 7'h3B}) && (in[31:25] != 7'h01)) || sysrw;
    e.r1a = e.r1e ? in[19:15] : 5'd0;
    e.r2a = e.r2e ? in[24:20] : 5'd0;
    e.rd  = e.we  ? in[11:7]  : 5'd0;
    e.sh  = (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) ? in[25:20] : 6'd0;
    case (op)
      7'h37, 7'h17: e.imm = {{32{in[31]}}, in[31:12], 12'h000};
      7'h6F:        e.imm = {{43{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      7'h63:        e.imm = {{51{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      7'h23:        e.imm = {{52{in[31]}}, in[31:25], in[11:7]};
      7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: e.imm = {{52{in[31]}}, in[31:20]};
      default:      e.imm = 64'd0;
    endcase
    return e;
  endfunction

  task automatic cmp_bundle(input exp_bnd_t e);
    check_val("pid_o", 64'(pid_o), 64'(e.pid));
    check_val("slot_vld_o", 64'(slot_vld_o), 64'(e.sv));
`ifdef DU_ILLEGAL_CHECK_EN
    check_val("illegal_o", 64'(illegal_o), 64'd0);
`endif
    for (int k = 0; k < WAYS; k++) begin
      check_val($sformatf("rd_addr%0d", k), 64'(rd_addr_o[k*5 +: 5]), 64'(e.w[k].rd));
      check_val($sformatf("rd_wen%0d", k),  64'(rd_wen_o[k]),         64'(e.w[k].we));
      check_val($sformatf("opcode%0d", k),  64'(opcode_o[k*7 +: 7]),  64'(e.w[k].opc));
      check_val($sformatf("funct3_%0d", k), 64'(funct3_o[k*3 +: 3]),  64'(e.w[k].f3));
      check_val($sformatf("funct7_%0d", k), 64'(funct7_o[k*7 +: 7]),  64'(e.w[k].f7));
      check_val($sformatf("shamt%0d", k),   64'(shamt_o[k*6 +: 6]),   64'(e.w[k].sh));
      check_val($sformatf("imm%0d", k),     imm_o[k*64 +: 64],        e.w[k].imm);
      check_val($sformatf("rs1_data%0d", k), rs1_data_o[k*64 +: 64],  e.w[k].d1);
      check_val($sformatf("rs2_data%0d", k), rs2_data_o[k*64 +: 64],  e.w[k].d2);
    end
  endtask

  // Scoreboard: pop/compare on handshake, then record accepted pushes.
  always @(negedge clk) begin
    if (rst || flush_i) begin
      sb_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) check_val("sb_underflow", 64'd1, 64'd0);
        else begin
          mon_e = sb_q.pop_front();
          cmp_bundle(mon_e);
        end
      end
      if (valid_i && ready_o) sb_q.push_back(cur);
    end
  end

  task automatic send(input logic [1:0] sv, input logic [3:0] pid,
                      input logic [31:0] i0, input logic [31:0] i1, input logic [63:0] d0);
    logic [63:0] b, c, d;
    bit ok;
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    d = {$urandom, $urandom};
    cur.sv   = sv;
    cur.pid  = pid;
    cur.w[0] = model_way(i0, sv[0], d0, b);
    cur.w[1] = model_way(i1, sv[1], c, d);
    slot_vld_i = sv;
    pid_i      = pid;
    inst_i     = {i1, i0};
    rs1_data_i = {c, d0};
    rs2_data_i = {d, b};
    valid_i    = 1'b1;
    #1;
    for (int k = 0; k < WAYS; k++) begin
      check_val($sformatf("rs1_addr%0d", k), 64'(rs1_addr_o[k*5 +: 5]), 64'(cur.w[k].r1a));
      check_val($sformatf("rs2_addr%0d", k), 64'(rs2_addr_o[k*5 +: 5]), 64'(cur.w[k].r2a));
      check_val($sformatf("rs1_ren%0d", k),  64'(rs1_ren_o[k]),         64'(cur.w[k].r1e));
      check_val($sformatf("rs2_ren%0d", k),  64'(rs2_ren_o[k]),         64'(cur.w[k].r2e));
    end
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
    end
    if (!ok) check_val("send_timeout", 64'd0, 64'd1);
    #1 valid_i = 1'b0;
  endtask

  logic [31:0] itab [16] = '{
    32'h00C58533, 32'h02C58533, 32'h00512423, 32'hFE208EE3,
    32'h800003B7, 32'h001000EF, 32'h30031273, 32'h00000073,
    32'h0104B403, 32'h0010051B, 32'h00C5A52F, 32'h00C58553,
    32'h40D7D693, 32'h00C5853B, 32'h00000297, 32'h8000006F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    slot_vld_i = '0; inst_i = '0; pid_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    cur = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("rst_valid_o", 64'(valid_o), 64'd0);
    check_val("rst_ready_o", 64'(ready_o), 64'd1);
    check_val("rst_rd_wen",  64'(rd_wen_o), 64'd0);
    check_val("rst_imm",     imm_o[63:0], 64'd0);

    // addi x5,x1,-1 / slli x3,x2,33 with one-cycle latency
    ready_i = 1'b1;
    send(2'b11, {2'd2, 2'd1}, 32'hFFF08293, 32'h02111193, 64'd7);
    check_val("lat_valid_o", 64'(valid_o), 64'd1);
    check_val("t1_rs1_data", rs1_data_o[63:0], 64'd7);
    check_val("t1_imm", imm_o[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("t1_rd", 64'(rd_addr_o[4:0]), 64'd5);
    check_val("t2_shamt", 64'(shamt_o[11:6]), 64'd33);
    @(posedge clk); #1;

    // fill to DEPTH, stall, then drain in order
    ready_i = 1'b0;
    send(2'b11, {2'd0, 2'd1}, itab[0], itab[1], 64'd11);
    send(2'b11, {2'd0, 2'd2}, itab[2], itab[3], 64'd12);
    check_val("full_ready_o", 64'(ready_o), 64'd0);
    fork
      send(2'b11, {2'd0, 2'd3}, itab[4], itab[5], 64'd13);
      begin repeat (2) @(posedge clk); #1 ready_i = 1'b1; end
    join
    repeat (4) @(posedge clk); #1;
    check_val("drained_valid_o", 64'(valid_o), 64'd0);

    // flush with a competing push
    ready_i = 1'b0;
    send(2'b11, 4'h5, itab[6], itab[7], 64'd14);
    valid_i = 1'b1; slot_vld_i = 2'b11; inst_i = {itab[9], itab[8]}; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check_val("flush_valid_o", 64'(valid_o), 64'd0);
    check_val("flush_ready_o", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_val("flush_dropped", 64'(valid_o), 64'd0);

    // reset while full
    ready_i = 1'b0;
    send(2'b11, 4'h6, itab[10], itab[11], 64'd15);
    send(2'b11, 4'h7, itab[12], itab[13], 64'd16);
    check_val("full2_ready_o", 64'(ready_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst2_valid_o", 64'(valid_o), 64'd0);
    check_val("rst2_ready_o", 64'(ready_o), 64'd1);
    check_val("rst2_opcode", 64'(opcode_o), 64'd0);
    check_val("rst2_rs1_data", rs1_data_o[63:0], 64'd0);

    // simultaneous push and pop at count 1
    send(2'b11, 4'h9, itab[14], itab[15], 64'd17);
    ready_i = 1'b1;
    send(2'b11, 4'hA, itab[0], itab[2], 64'd18);
    check_val("pp_valid_o", 64'(valid_o), 64'd1);
    check_val("pp_ready_o", 64'(ready_o), 64'd1);
    repeat (3) @(posedge clk); #1;

    // way1 invalid with garbage instruction
    send(2'b01, 4'h3, 32'hFFF08293, 32'hFFFFFFFF, 64'd19);
    check_val("sv01_rd1", 64'(rd_addr_o[9:5]), 64'd0);
    check_val("sv01_imm1", imm_o[127:64], 64'd0);
    check_val("sv01_rd0", 64'(rd_addr_o[4:0]), 64'd5);
    repeat (2) @(posedge clk); #1;

    // mixed opcode traffic with periodic back-pressure
    for (int i = 0; i < 8; i++) begin
      ready_i = (i % 3) != 2;
      send(2'b11, 4'($urandom_range(0, 15)), itab[2*i], itab[2*i+1], {$urandom, $urandom});
    end
    ready_i = 1'b1;
    repeat (6) @(posedge clk); #1;
    check_val("sb_leftover", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
